regfile_scoreboard: RTL and testbench

Parametrised register file: NUM_REGS x DATA_W, two combinational read ports, one write port, optional hardwired-zero register 0, optional write-to-read bypass. Adds a per-register scoreboard (busy bits set at issue, cleared at writeback), a stall output, and an outstanding-write counter. Successor to the single-cycle 32x64 register file, for pipelined/multicycle cores where writeback lags issue.

---
 rtl/regfile_scoreboard.sv | 118 +++++++++++
 tb/tb_regfile_scoreboard.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port and a
// per-register busy scoreboard that tracks writebacks still outstanding after issue.
module regfile_scoreboard #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                issue_valid,
  input  logic                issue_wr,
  input  logic [ADDR_W-1:0]   issue_dst,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [ADDR_W:0]     pending
);

  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic [ADDR_W:0]     pending_reg;
  logic [ADDR_W:0]     pending_next;

  logic [NUM_REGS-1:0] wr_sel;
  logic [NUM_REGS-1:0] set_sel;
  logic [NUM_REGS-1:0] eff_busy;
  logic                set_fire;
  logic                pend_inc;
  logic                pend_dec;

  logic [ADDR_W-1:0]   rd_addr [2];
  logic [DATA_W-1:0]   rd_data [2];

  assign rd_addr[0] = rd_addr1;
  assign rd_addr[1] = rd_addr2;
  assign rd_data1   = rd_data[0];
  assign rd_data2   = rd_data[1];

  // A source or destination blocks issue only while its busy bit is set and
  // no forwarding writeback retires it in this same cycle.
  assign stall = issue_valid &&
                 (eff_busy[rd_addr1] || eff_busy[rd_addr2] ||
                  (issue_wr && eff_busy[issue_dst]));

  assign set_fire = issue_valid && !stall && issue_wr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);

      assign wr_sel[gi]   = wr_en && (wr_addr == ADDR_W'(gi));
      assign set_sel[gi]  = set_fire && (issue_dst == ADDR_W'(gi)) && !IS_ZERO;
      assign eff_busy[gi] = IS_ZERO ? 1'b0
                                    : (busy_reg[gi] && !((BYPASS != 0) && wr_sel[gi]));

      // New producer owns the register when issue and writeback hit it together.
      assign busy_next[gi] = set_sel[gi] ? 1'b1 :
                             wr_sel[gi]  ? 1'b0 : busy_reg[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_reg[gi] <= '0;
        end else if (wr_sel[gi] && !IS_ZERO) begin
          regs_reg[gi] <= wr_data;
        end
      end
    end

    for (gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_data[gi] = regs_reg[rd_addr[gi]];
        if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr[gi])) begin
          rd_data[gi] = wr_data;
        end
        if ((ZERO_REG != 0) && (rd_addr[gi] == '0)) begin
          rd_data[gi] = '0;
        end
      end
    end
  endgenerate

  // set_sel and wr_sel are one-hot, so each edge moves the count by at most one each way.
  assign pend_inc = |(set_sel & ~busy_reg);
  assign pend_dec = |(wr_sel & busy_reg & ~set_sel);

  always_comb begin
    pending_next = pending_reg;
    if (pend_inc && !pend_dec) begin
      pending_next = pending_reg + 1'b1;
    end else if (pend_dec && !pend_inc) begin
      pending_next = pending_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg    <= '0;
      pending_reg <= '0;
    end else begin
      busy_reg    <= busy_next;
      pending_reg <= pending_next;
    end
  end

  assign busy_vec = busy_reg;
  assign pending  = pending_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus randomized traffic
// compared every cycle against an array-based model of the register/scoreboard rules.
module tb_regfile_scoreboard;
  localparam int NR = 32;
  localparam int DW = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, issue_dst = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0, issue_valid = 1'b0, issue_wr = 1'b0;

  logic [DW-1:0] rd_data1, rd_data2, nb_rd_data1, nb_rd_data2;
  logic          stall, nb_stall;
  logic [NR-1:0] busy_vec, nb_busy_vec;
  logic [AW:0]   pending, nb_pending;

  logic [2:0]  p_rd_addr1 = '0, p_rd_addr2 = '0, p_wr_addr = '0, p_issue_dst = '0;
  logic [15:0] p_wr_data = '0;
  logic        p_wr_en = 1'b0, p_issue_valid = 1'b0, p_issue_wr = 1'b0;
  logic [15:0] p_rd_data1, p_rd_data2;
  logic        p_stall;
  logic [7:0]  p_busy_vec;
  logic [3:0]  p_pending;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_dst(issue_dst), .stall(stall), .busy_vec(busy_vec), .pending(pending));

  regfile_scoreboard #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(nb_rd_data1), .rd_data2(nb_rd_data2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_dst(issue_dst), .stall(nb_stall), .busy_vec(nb_busy_vec), .pending(nb_pending));

  regfile_scoreboard #(.NUM_REGS(8), .DATA_W(16), .ZERO_REG(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .rd_addr1(p_rd_addr1), .rd_addr2(p_rd_addr2),
    .rd_data1(p_rd_data1), .rd_data2(p_rd_data2), .wr_en(p_wr_en), .wr_addr(p_wr_addr),
    .wr_data(p_wr_data), .issue_valid(p_issue_valid), .issue_wr(p_issue_wr),
    .issue_dst(p_issue_dst), .stall(p_stall), .busy_vec(p_busy_vec), .pending(p_pending));

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model of the default configuration ----------------
  logic [63:0] m_regs [NR];
  logic        m_busy [NR];

  function automatic logic m_eb(input logic [AW-1:0] r);
    return (r != 0) && m_busy[r] && !(wr_en && wr_addr == r);
  endfunction

  function automatic logic m_stall();
    return issue_valid && (m_eb(rd_addr1) || m_eb(rd_addr2) || (issue_wr && m_eb(issue_dst)));
  endfunction

  function automatic logic [63:0] m_rd(input logic [AW-1:0] a);
    if (a == 0) return 64'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic [63:0] m_busy_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [63:0] m_pending();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
    return 64'(c);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) m_regs[wr_addr] <= wr_data;
      if (wr_en) m_busy[wr_addr] <= 1'b0;
      // later assignment wins: a new producer keeps the bit set
      if (issue_valid && !m_stall() && issue_wr && issue_dst != 0) m_busy[issue_dst] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("cmp_rd_data1", rd_data1, m_rd(rd_addr1));
    check("cmp_rd_data2", rd_data2, m_rd(rd_addr2));
    check("cmp_stall",    {63'd0, stall}, {63'd0, m_stall()});
    check("cmp_busy_vec", busy_vec, m_busy_vec());
    check("cmp_pending",  pending,  m_pending());
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit we, input int wa, input logic [63:0] wd, input bit iv,
                       input bit iw, input int dst, input int s1, input int s2);
    @(posedge clk); #1;
    wr_en = we; wr_addr = wa[AW-1:0]; wr_data = wd;
    issue_valid = iv; issue_wr = iw; issue_dst = dst[AW-1:0];
    rd_addr1 = s1[AW-1:0]; rd_addr2 = s2[AW-1:0];
    @(negedge clk);
  endtask

  task automatic p_drive(input bit we, input int wa, input logic [15:0] wd, input bit iv,
                         input bit iw, input int dst, input int s1, input int s2);
    @(posedge clk); #1;
    p_wr_en = we; p_wr_addr = wa[2:0]; p_wr_data = wd;
    p_issue_valid = iv; p_issue_wr = iw; p_issue_dst = dst[2:0];
    p_rd_addr1 = s1[2:0]; p_rd_addr2 = s2[2:0];
    @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    drive(0, 0, 0, 0, 0, 0, 3, 0);
    check("rst_busy_vec", busy_vec, 64'd0);
    check("rst_pending", pending, 64'd0);
    check("rst_rd3", rd_data1, 64'd0);

    // write / read / zero register / bypass
    drive(1, 3, 64'hDEADBEEFCAFEF00D, 0, 0, 0, 3, 0);
    check("bypass_rd3", rd_data1, 64'hDEADBEEFCAFEF00D);
    drive(1, 0, 64'h1234, 0, 0, 0, 3, 0);
    check("readback_rd3", rd_data1, 64'hDEADBEEFCAFEF00D);
    check("model_rd3", m_rd(5'd3), 64'hDEADBEEFCAFEF00D);
    drive(1, 7, 64'hAA, 0, 0, 0, 7, 0);
    check("zero_reg_rd0", rd_data2, 64'd0);
    check("bypass_rd7", rd_data1, 64'hAA);
    check("nb_no_bypass_rd7", nb_rd_data1, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 7, 0);
    check("nb_rd7_next", nb_rd_data1, 64'hAA);

    // RAW stall
    drive(0, 0, 0, 1, 1, 5, 0, 0);
    check("issue5_stall", {63'd0, stall}, 64'd0);
    drive(0, 0, 0, 1, 0, 0, 5, 0);
    check("issue5_busy", busy_vec, 64'h20);
    check("issue5_pending", pending, 64'd1);
    check("model_pending1", m_pending(), 64'd1);
    check("raw_stall", {63'd0, stall}, 64'd1);
    check("nb_raw_stall", {63'd0, nb_stall}, 64'd1);
    drive(1, 5, 64'h5555, 1, 0, 0, 5, 0);
    check("stall_no_change", busy_vec, 64'h20);
    check("wb_bypass_unblock", {63'd0, stall}, 64'd0);
    check("nb_wb_still_stall", {63'd0, nb_stall}, 64'd1);
    drive(0, 0, 0, 1, 0, 0, 5, 0);
    check("wb5_busy", busy_vec, 64'd0);
    check("wb5_pending", pending, 64'd0);
    check("nb_next_unblock", {63'd0, nb_stall}, 64'd0);

    // WAW and set-wins
    drive(0, 0, 0, 1, 1, 9, 0, 0);
    check("issue9_stall", {63'd0, stall}, 64'd0);
    drive(0, 0, 0, 1, 1, 9, 0, 0);
    check("waw_stall", {63'd0, stall}, 64'd1);
    drive(1, 9, 64'h99, 1, 1, 9, 0, 0);
    check("setwin_stall", {63'd0, stall}, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("setwin_busy", busy_vec, 64'h200);
    check("setwin_pending", pending, 64'd1);
    drive(1, 9, 64'h9, 0, 0, 0, 0, 0);

    // counter fill and drain
    for (int d = 1; d < NR; d++) drive(0, 0, 0, 1, 1, d, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0, 0);
    check("fill_pending", pending, 64'd31);
    check("fill_busy", busy_vec, 64'hFFFFFFFE);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("dst0_busy", busy_vec, 64'hFFFFFFFE);
    for (int d = 1; d < NR; d++) drive(1, d, {$urandom, $urandom}, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("drain_pending", pending, 64'd0);

    // asynchronous reset mid-operation
    drive(0, 0, 0, 1, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 2, 0, 0);
    drive(1, 5, 64'hBEEF, 0, 0, 0, 5, 0);
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    check("pre_rst_busy", busy_vec, 64'h6);
    check("pre_rst_rd5", rd_data1, 64'hBEEF);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy_vec, 64'd0);
    check("async_rst_pending", pending, 64'd0);
    check("async_rst_rd5", rd_data1, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // small configuration with a real register 0
    p_drive(1, 0, 16'hBEEF, 0, 0, 0, 0, 0);
    p_drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("p_reg0_write", p_rd_data1, 64'hBEEF);
    for (int d = 0; d < 8; d++) p_drive(0, 0, 0, 1, 1, d, d, d);
    p_drive(0, 0, 0, 1, 0, 0, 0, 0);
    check("p_full_pending", p_pending, 64'd8);
    check("p_full_busy", p_busy_vec, 64'hFF);
    check("p_reg0_stall", {63'd0, p_stall}, 64'd1);
    for (int d = 0; d < 8; d++) p_drive(1, d, 16'(d), 0, 0, 0, 0, 0);
    p_drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("p_drain_pending", p_pending, 64'd0);

    // randomized traffic, narrow address range half the time to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      int hi;
      hi = ($urandom_range(0, 1) == 0) ? 7 : 31;
      if (i == 1500) begin
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
      end
      drive($urandom_range(0, 2) == 0, $urandom_range(0, hi), {$urandom, $urandom},
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
